// File: rtl/servant_timer_rearm.sv
// Wishbone initiator that re-arms servant_timer on each interrupt: it reads mtime, writes
// mtimecmp = mtime + PERIOD and pulses o_tick when the write is accepted.
module servant_timer_rearm #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned PERIOD = 1000,
  parameter logic [31:0] ADDR   = 32'h8000_0000,
  parameter int unsigned SETTLE = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic        i_irq,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic        o_tick,
  output logic        o_busy,
  output logic [7:0]  o_overrun
);

  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [WIDTH-1:0] LP_PERIOD = PERIOD[WIDTH-1:0];

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StHold} state_e;

  state_e      r_state;
  logic [CW-1:0] r_cnt;
  logic [7:0]  r_overrun;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic [3:0]  r_sel;
  logic        r_we;
  logic        r_cyc;
  logic        r_tick;
  logic        r_busy;

  logic [WIDTH-1:0] w_target;

  // Wraps modulo 2**WIDTH; a wrapped target is accepted and simply retried via HOLD.
  assign w_target = i_wb_rdt[WIDTH-1:0] + LP_PERIOD;

  if (WIDTH < 32) begin : g_unused
    logic w_unused_rdt;
    assign w_unused_rdt = ^i_wb_rdt[31:WIDTH];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_overrun <= '0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_sel     <= '0;
      r_we      <= 1'b0;
      r_cyc     <= 1'b0;
      r_tick    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_en && i_irq) begin
            r_state <= StRead;
            r_cyc   <= 1'b1;
            r_we    <= 1'b0;
            r_adr   <= ADDR;
            r_sel   <= 4'hF;
            r_busy  <= 1'b1;
          end
        end
        StRead: begin
          if (i_wb_ack) begin
            r_state <= StWrite;
            r_we    <= 1'b1;
            r_dat   <= 32'(w_target);
          end
        end
        StWrite: begin
          if (i_wb_ack) begin
            r_state <= StHold;
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_sel   <= '0;
            r_tick  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        StHold: begin
          if (!i_irq) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end else if (r_cnt == CW'(SETTLE - 1)) begin
            // Interrupt did not clear: count the overrun and retry from a fresh read.
            if (r_overrun != 8'hFF) r_overrun <= r_overrun + 8'd1;
            r_state <= StRead;
            r_cyc   <= 1'b1;
            r_we    <= 1'b0;
            r_adr   <= ADDR;
            r_sel   <= 4'hF;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_wb_adr  = r_adr;
  assign o_wb_dat  = r_dat;
  assign o_wb_sel  = r_sel;
  assign o_wb_we   = r_we;
  assign o_wb_cyc  = r_cyc;
  assign o_tick    = r_tick;
  assign o_busy    = r_busy;
  assign o_overrun = r_overrun;

endmodule

// File: tb/tb_servant_timer_rearm.sv
// Directed bench for servant_timer_rearm with a wait-state Wishbone slave and bus monitor.
module tb_servant_timer_rearm;

  localparam logic [31:0] ADDR = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic        irq = 1'b0;
  logic [31:0] adr, dat, rdt;
  logic [3:0]  sel;
  logic        we, cyc, ack, tick, busy;
  logic [7:0]  overrun;

  logic [3:0]  rwait = 4'd0;
  logic [3:0]  wwait = 4'd0;
  logic [3:0]  wcnt = 4'd0;

  int errors = 0;
  int checks = 0;

  // Monitor counters (written only by the monitor) and baselines (written only by main).
  int n_cyc = 0, n_we = 0, n_rise = 0, n_bad = 0, n_rd = 0, n_wr = 0, n_tick = 0;
  int b_cyc, b_we, b_rise, b_bad, b_rd, b_wr, b_tick;
  logic prev_cyc = 1'b0;

  always #5 clk = ~clk;

  servant_timer_rearm #(
    .WIDTH (16),
    .PERIOD(1000),
    .ADDR  (ADDR),
    .SETTLE(2)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_en     (en),
    .i_irq    (irq),
    .o_wb_adr (adr),
    .o_wb_dat (dat),
    .o_wb_sel (sel),
    .o_wb_we  (we),
    .o_wb_cyc (cyc),
    .i_wb_rdt (rdt),
    .i_wb_ack (ack),
    .o_tick   (tick),
    .o_busy   (busy),
    .o_overrun(overrun)
  );

  assign ack = cyc && (wcnt == (we ? wwait : rwait));

  always @(posedge clk) begin
    if (!cyc || ack) wcnt <= 4'd0;
    else             wcnt <= wcnt + 4'd1;
  end

  always @(negedge clk) begin
    prev_cyc <= cyc;
    if (cyc && !prev_cyc) n_rise <= n_rise + 1;
    if (cyc) begin
      n_cyc <= n_cyc + 1;
      if (we) n_we <= n_we + 1;
      if (adr !== ADDR || sel !== 4'hF) n_bad <= n_bad + 1;
      if (ack && !we) n_rd <= n_rd + 1;
      if (ack && we)  n_wr <= n_wr + 1;
    end else if (adr !== 32'd0 || sel !== 4'd0 || we !== 1'b0) begin
      n_bad <= n_bad + 1;
    end
    if (tick) n_tick <= n_tick + 1;
  end

  `define CHECK(tag, obs, exp) \
    checks++; \
    assert ((obs) === (exp)) else begin \
      errors++; \
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); \
    end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_cyc = n_cyc; b_we = n_we; b_rise = n_rise; b_bad = n_bad;
    b_rd = n_rd; b_wr = n_wr; b_tick = n_tick;
  endtask

  initial begin
    rdt = 32'd0;
    #1 rst = 1'b1;
    step(2);
    `CHECK("rst_cyc", cyc, 1'b0)
    `CHECK("rst_adr", adr, 32'd0)
    `CHECK("rst_dat", dat, 32'd0)
    `CHECK("rst_sel", sel, 4'd0)
    `CHECK("rst_busy", busy, 1'b0)
    `CHECK("rst_ovr", overrun, 8'd0)
    rst = 1'b0;
    step(1);

    // 1: zero-wait, rdt=500, single irq pulse
    en = 1'b1; rdt = 32'd500; irq = 1'b1; snap();
    step(1);
    irq = 1'b0;
    `CHECK("t1_cyc", cyc, 1'b1)
    `CHECK("t1_we_rd", we, 1'b0)
    `CHECK("t1_adr", adr, ADDR)
    `CHECK("t1_sel", sel, 4'hF)
    step(1);
    `CHECK("t1_we_wr", we, 1'b1)
    `CHECK("t1_dat", dat, 32'd1500)
    step(1);
    `CHECK("t1_tick", tick, 1'b1)
    `CHECK("t1_cyc_off", cyc, 1'b0)
    step(1);
    `CHECK("t1_tick_off", tick, 1'b0)
    `CHECK("t1_idle", busy, 1'b0)
    `CHECK("t1_ovr", overrun, 8'd0)
    `CHECK("t1_nrd", n_rd - b_rd, 1)
    `CHECK("t1_nwr", n_wr - b_wr, 1)
    `CHECK("t1_ntick", n_tick - b_tick, 1)

    // 2: wrapped target, irq held through HOLD
    rdt = 32'h0000_FF00; irq = 1'b1; snap();
    step(3);
    `CHECK("t2_tick", tick, 1'b1)
    `CHECK("t2_dat", dat, 32'h0000_02E8)
    step(2);
    `CHECK("t2_ovr", overrun, 8'd1)
    `CHECK("t2_retry_cyc", cyc, 1'b1)
    `CHECK("t2_retry_we", we, 1'b0)
    irq = 1'b0;
    step(4);
    `CHECK("t2_idle", busy, 1'b0)
    `CHECK("t2_nrd", n_rd - b_rd, 2)
    `CHECK("t2_ntick", n_tick - b_tick, 2)
    `CHECK("t2_ovr_hold", overrun, 8'd1)

    // 3: 3 read wait states, 2 write wait states
    rwait = 4'd3; wwait = 4'd2; rdt = 32'd500; irq = 1'b1; snap();
    step(1);
    irq = 1'b0;
    step(12);
    `CHECK("t3_cyc_len", n_cyc - b_cyc, 7)
    `CHECK("t3_we_len", n_we - b_we, 3)
    `CHECK("t3_cyc_rise", n_rise - b_rise, 1)
    `CHECK("t3_bus", n_bad - b_bad, 0)
    `CHECK("t3_ntick", n_tick - b_tick, 1)
    `CHECK("t3_dat", dat, 32'd1500)
    `CHECK("t3_idle", busy, 1'b0)

    // 4: async reset in WRITE between edges
    rwait = 4'd0; wwait = 4'd8; irq = 1'b1;
    step(1);
    irq = 1'b0;
    step(1);
    `CHECK("t4_in_write", we, 1'b1)
    #2 rst = 1'b1;
    #1;
    `CHECK("t4_cyc", cyc, 1'b0)
    `CHECK("t4_we", we, 1'b0)
    `CHECK("t4_adr", adr, 32'd0)
    `CHECK("t4_dat", dat, 32'd0)
    `CHECK("t4_sel", sel, 4'd0)
    `CHECK("t4_busy", busy, 1'b0)
    `CHECK("t4_ovr", overrun, 8'd0)
    step(1);
    rst = 1'b0; en = 1'b0; wwait = 4'd0;
    step(1);
    snap(); irq = 1'b1;
    step(1);
    irq = 1'b0;
    step(4);
    `CHECK("t4_no_start", n_rise - b_rise, 0)
    `CHECK("t4_stay_idle", busy, 1'b0)

    // 5: en dropped during READ
    en = 1'b1; rwait = 4'd2; rdt = 32'd500; irq = 1'b1; snap();
    step(1);
    en = 1'b0; irq = 1'b0;
    `CHECK("t5_busy", busy, 1'b1)
    step(8);
    `CHECK("t5_ntick", n_tick - b_tick, 1)
    `CHECK("t5_nwr", n_wr - b_wr, 1)
    `CHECK("t5_idle", busy, 1'b0)
    irq = 1'b1;
    step(2);
    irq = 1'b0;
    step(3);
    `CHECK("t5_no_restart", n_rise - b_rise, 1)

    // 6: irq tied high, overrun saturates
    en = 1'b1; rwait = 4'd0; irq = 1'b1; snap();
    step(1300);
    `CHECK("t6_sat", overrun, 8'hFF)
    `CHECK("t6_busy", busy, 1'b1)
    `CHECK("t6_many_retries", (n_tick - b_tick) >= 300, 1'b1)
    irq = 1'b0; en = 1'b0;
    step(6);
    `CHECK("t6_idle", busy, 1'b0)
    `CHECK("t6_sat_hold", overrun, 8'hFF)

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
